// File: rtl/demux64x1_2.sv
`default_nettype none
// ============================================================================
//  Module   : demux64x1_2
//  Purpose  : Routes a 64-bit valid/ready stream to one of two output streams,
//             each buffered by its own DEPTH-entry FIFO with a delivery counter.
//  Revision : 1.0  initial release
// ============================================================================
module demux64x1_2 #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_a_data,
    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [63:0] out_b_data,
    output logic        out_b_valid,
    input  logic        out_b_ready,
    output logic [15:0] count_a,
    output logic [15:0] count_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [1:0]  w_full;
    logic [1:0]  w_empty;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_out_ready;
    logic        w_accept;
    logic [63:0] w_head  [2];
    logic [15:0] w_count [2];

    // Ready looks only at the addressed FIFO's fullness, never at the sinks.
    assign in_ready    = ~w_full[in_sel];
    assign w_accept    = in_valid & in_ready;
    assign w_push[0]   = w_accept & ~in_sel;
    assign w_push[1]   = w_accept &  in_sel;
    assign w_out_ready = {out_b_ready, out_a_ready};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [PW-1:0] r_wr_ptr;
            logic [PW-1:0] r_rd_ptr;
            logic [15:0]   r_count;
            logic [63:0]   r_mem [DEPTH];

            assign w_empty[p] = (r_wr_ptr == r_rd_ptr);
            assign w_full[p]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
            assign w_pop[p]   = ~w_empty[p] & w_out_ready[p];
            assign w_head[p]  = r_mem[r_rd_ptr[AW-1:0]];
            assign w_count[p] = r_count;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[p]) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                    end
                    if (w_pop[p]) begin
                        r_rd_ptr <= r_rd_ptr + PW'(1);
                        r_count  <= r_count + 16'd1;
                    end
                end
            end

            // Storage needs no reset: contents are only visible behind valid.
            always_ff @(posedge clk) begin
                if (w_push[p]) begin
                    r_mem[r_wr_ptr[AW-1:0]] <= in_data;
                end
            end
        end
    endgenerate

    assign out_a_data  = w_head[0];
    assign out_a_valid = ~w_empty[0];
    assign out_b_data  = w_head[1];
    assign out_b_valid = ~w_empty[1];
    assign count_a     = w_count[0];
    assign count_b     = w_count[1];

endmodule
`default_nettype wire

// File: doc/demux64x1_2.md
DEMUX64X1_2 -- requirements
Module: demux64x1_2

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_data  input  64  source word.
REQ-004 SHALL have ports: in_sel  input  1  destination select (0 = port A, 1 = port B).
REQ-005 SHALL have ports: in_valid  input  1  source word and select are valid.
REQ-006 SHALL have ports: in_ready  output  1  block accepts the word for the currently selected port.
REQ-007 SHALL have ports: out_a_data  output  64; out_a_valid  output  1; out_a_ready  input  1  (port A stream).
REQ-008 SHALL have ports: out_b_data  output  64; out_b_valid  output  1; out_b_ready  input  1  (port B stream).
REQ-009 SHALL have ports: count_a, count_b  output  16 each  delivered-word counters per port.
REQ-010 SHALL have parameter: DEPTH, default 2, per-port buffer entries (power of two, 2..8).

Function
REQ-011 SHALL provide one independent FIFO of DEPTH 64-bit entries per output port.
REQ-012 SHALL define input accept as in_valid && in_ready on a rising clk edge.
REQ-013 SHALL drive in_ready = NOT full of the FIFO addressed by in_sel; in_ready SHALL NOT depend combinationally on out_a_ready or out_b_ready.
REQ-014 SHALL write an accepted word only into the FIFO addressed by in_sel; the other FIFO SHALL be unchanged.
REQ-015 SHALL drive out_x_valid = NOT empty of FIFO x, and out_x_data = head entry of FIFO x.
REQ-016 SHALL define a port-x delivery as out_x_valid && out_x_ready on a rising clk edge; delivery pops the head.
REQ-017 SHALL present an accepted word at its port on the cycle after acceptance if that FIFO was empty (latency 1 cycle).
REQ-018 SHALL preserve per-port order; no ordering is implied between ports A and B.
REQ-019 SHALL support push and pop of the same FIFO in one cycle when it is non-empty, keeping the occupancy unchanged; when full, in_ready for that port stays 0 regardless of out_x_ready.
REQ-020 SHALL hold out_x_data stable while out_x_valid=1 and out_x_ready=0.
REQ-021 SHALL keep in_ready meaningful and in_data/in_sel ignored when in_valid=0; a change of in_sel with in_valid=0 SHALL have no effect on state.
REQ-022 SHALL use read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full = same index with opposite wrap bit, empty = pointers equal.
REQ-023 SHALL increment count_x by 1 on each port-x delivery, wrapping 16'hFFFF -> 16'h0000 with no flag.
REQ-024 SHALL allow deliveries on A and B and an accept in the same cycle, all taking effect.

Reset
REQ-025 SHALL, while reset_n=0, force both FIFOs empty, both pointers to 0, count_a = count_b = 0, out_a_valid = out_b_valid = 0.
REQ-026 SHALL drive in_ready = 1 during reset so that it reflects the empty state, and SHALL accept nothing while reset_n=0.
REQ-027 SHALL discard all buffered words on reset asserted mid-operation; no partial word SHALL appear after release.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.
REQ-029 SHALL leave out_x_data value unspecified while out_x_valid=0.

Verification
REQ-030 SHALL verify single routing: reset, in_sel=0, in_data=64'h0000000000100000, in_valid=1 one cycle, out_a_ready=1 -> out_a_valid=1 next cycle with that data, out_b_valid stays 0, count_a=1.
REQ-031 SHALL verify backpressure/full: out_b_ready=0, push 3 words to B (DEPTH=2) -> first two accepted, in_ready=0 on the third; raise out_b_ready -> words delivered in order 1,2 and then the third is accepted.
REQ-032 SHALL verify port independence: B full with out_b_ready=0, in_sel=0 -> in_ready=1 and A words 64'h00000007b0000000 and 64'h000000000000001a delivered on A in order.
REQ-033 SHALL verify simultaneous push/pop: A holding one word, out_a_ready=1, accept a new A word in the same cycle -> occupancy stays 1 and the stream is unbroken.
REQ-034 SHALL verify counter wrap: force 65536 deliveries on B -> count_b returns to 16'h0000, count_a unchanged.
REQ-035 SHALL verify reset mid-operation: both FIFOs full, pulse reset_n=0 asynchronously between edges -> out_a_valid = out_b_valid = 0 and both counts 0 immediately, and no stale word after release.
